// File: rtl/bit_serial_alu.sv
// bit_serial_alu: width-generic bit-serial unsigned ALU built around a single
// full adder and one carry flop. Operands are processed LSB first.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high; aborts any operation in flight
//   start   request, sampled only while idle
//   mode    00 add, 01 subtract, 10 multiply, 11 reserved (flags err)
//   a, b    N-bit operands (a = multiplicand, b = multiplier for MUL)
//   busy    high while an operation is in progress
//   done    one-cycle completion pulse
//   err     high together with done when the latched mode was 11
//   result  2N-bit result, only written at completion
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start
// ADDSUB    | one sum bit per edge (also the single reserved-mode edge)
// MUL_ADD   | serial add of a (or zero) into the upper half of P
// MUL_SHIFT | shift P right, pulling in the add carry
// FIN       | done/err pulse, back to IDLE next edge
module bit_serial_alu #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     mode,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [2*N-1:0] result
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_RES = 2'b11;

  typedef enum logic [2:0] {IDLE, ADDSUB, MUL_ADD, MUL_SHIFT, FIN} state_t;

  state_t          state, state_n;
  logic [N-1:0]    opa, opb;
  logic [1:0]      mode_r;
  logic            carry;
  logic [2*N-1:0]  p;
  logic [CW-1:0]   cnt, icnt;
  logic            cnt_last, icnt_last;
  logic            fa_x, fa_y, fa_s, fa_c;

  assign cnt_last  = (cnt == LAST);
  assign icnt_last = (icnt == LAST);

  // Operands rotate right one place per edge, so bit 0 is always the
  // current bit and a full pass of N edges restores them for the next
  // multiply iteration. The upper half of P doubles as the sum register.
  always_comb begin
    fa_x = opa[0];
    fa_y = (mode_r == MODE_SUB) ? ~opb[0] : opb[0];
    if (state == MUL_ADD) begin
      fa_x = p[N];
      fa_y = opb[0] & opa[0];
    end
    fa_s = fa_x ^ fa_y ^ carry;
    fa_c = (fa_x & fa_y) | (fa_x & carry) | (fa_y & carry);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (start) state_n = (mode == MODE_MUL) ? MUL_ADD : ADDSUB;
      ADDSUB:    if (mode_r == MODE_RES || cnt_last) state_n = FIN;
      MUL_ADD:   if (cnt_last) state_n = MUL_SHIFT;
      MUL_SHIFT: state_n = icnt_last ? FIN : MUL_ADD;
      FIN:       state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  assign busy = (state == ADDSUB) || (state == MUL_ADD) || (state == MUL_SHIFT);
  assign done = (state == FIN);
  assign err  = done && (mode_r == MODE_RES);

  always_ff @(posedge clk) begin
    if (reset) begin
      opa    <= '0;
      opb    <= '0;
      mode_r <= MODE_ADD;
      carry  <= 1'b0;
      p      <= '0;
      cnt    <= '0;
      icnt   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opa    <= a;
          opb    <= b;
          mode_r <= mode;
          carry  <= (mode == MODE_SUB);
          p      <= '0;
          cnt    <= '0;
          icnt   <= '0;
        end
        ADDSUB: begin
          if (mode_r == MODE_RES) begin
            result <= '0;
          end else begin
            p[2*N-1:N] <= {fa_s, p[2*N-1:N+1]};
            carry      <= fa_c;
            opa        <= {opa[0], opa[N-1:1]};
            opb        <= {opb[0], opb[N-1:1]};
            cnt        <= cnt + CW'(1);
            // For subtract the final carry is inverted to give the borrow.
            if (cnt_last)
              result <= {{(N-1){1'b0}}, (mode_r == MODE_SUB) ? ~fa_c : fa_c,
                         fa_s, p[2*N-1:N+1]};
          end
        end
        MUL_ADD: begin
          p[2*N-1:N] <= {fa_s, p[2*N-1:N+1]};
          carry      <= fa_c;
          opa        <= {opa[0], opa[N-1:1]};
          cnt        <= cnt_last ? '0 : cnt + CW'(1);
        end
        MUL_SHIFT: begin
          p     <= {carry, p[2*N-1:1]};
          carry <= 1'b0;
          opb   <= {1'b0, opb[N-1:1]};
          icnt  <= icnt + CW'(1);
          if (icnt_last) result <= {carry, p[2*N-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu.sv
module tb_bit_serial_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start4, start8;
  logic [1:0]  mode4, mode8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, err4, busy8, done8, err8;
  logic [7:0]  result4;
  logic [15:0] result8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bit_serial_alu #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .mode(mode4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .err(err4), .result(result4)
  );

  bit_serial_alu #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .err(err8), .result(result8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic int model(input int n, input int m, input int x, input int y);
    int mask;
    mask = (1 << n) - 1;
    case (m)
      0:       model = x + y;
      1:       model = ((x - y) & mask) | ((x < y) ? (1 << n) : 0);
      2:       model = x * y;
      default: model = 0;
    endcase
  endfunction

  function automatic int latency(input int n, input int m);
    case (m)
      2:       latency = n * (n + 1);
      3:       latency = 1;
      default: latency = n;
    endcase
  endfunction

  // Runs one N=4 operation and reports observations; the calling test compares.
  task automatic do_op4(input logic [1:0] m, input logic [3:0] x, input logic [3:0] y,
                        input bit scramble, output int lat, output logic [7:0] res,
                        output logic err_at_done, output bit hs_ok, output bit stable,
                        output logic done_after);
    logic [7:0] prev;
    prev = result4;
    start4 = 1'b1; mode4 = m; a4 = x; b4 = y;
    tick;
    start4 = 1'b0;
    hs_ok = (busy4 === 1'b1) && (done4 === 1'b0);
    lat = -1; stable = 1'b1; res = 'x; err_at_done = 1'bx;
    for (int k = 1; k <= 100; k++) begin
      if (scramble) begin
        a4 = 4'($urandom); b4 = 4'($urandom);
        mode4 = 2'($urandom); start4 = 1'($urandom);
      end
      tick;
      if (done4 === 1'b1) begin
        lat = k; res = result4; err_at_done = err4;
        if (busy4 !== 1'b0) hs_ok = 1'b0;
        break;
      end
      if (busy4 !== 1'b1 || result4 !== prev) stable = 1'b0;
    end
    start4 = 1'b0;
    tick;
    done_after = done4;
  endtask

  task automatic test_reset;
    reset = 1'b1; start4 = 1'b1; start8 = 1'b1;
    mode4 = 2'd0; a4 = 4'd5; b4 = 4'd5; mode8 = 2'd2; a8 = 8'd3; b8 = 8'd3;
    tick; tick;
    reset = 1'b0; start4 = 1'b0; start8 = 1'b0;
    tick;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done4); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err4); end
    checks++; if (result4 !== 8'h00) begin errors++; $display("FAIL reset_result got=%h want=00", result4); end
    checks++; if (busy8 !== 1'b0 || result8 !== 16'h0) begin
      errors++; $display("FAIL reset_n8 got busy=%b result=%h want busy=0 result=0000", busy8, result8);
    end
    tick; tick;
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored got busy=%b done=%b want 0 0", busy4, done4);
    end
  endtask

  task automatic test_arith(input logic [1:0] m, input int nrand, input bit scramble);
    logic [3:0] dx [2];
    logic [3:0] dy [2];
    logic [3:0] x, y;
    logic [7:0] exp_res, res;
    int         exp_lat, lat;
    logic       err_at_done, done_after;
    bit         hs_ok, stable;
    case (m)
      2'd0:    begin dx[0] = 4'd9;  dy[0] = 4'd8; dx[1] = 4'd15; dy[1] = 4'd15; end
      2'd1:    begin dx[0] = 4'd3;  dy[0] = 4'd5; dx[1] = 4'd5;  dy[1] = 4'd3;  end
      2'd2:    begin dx[0] = 4'd15; dy[0] = 4'd15; dx[1] = 4'd0; dy[1] = 4'd13; end
      default: begin dx[0] = 4'd7;  dy[0] = 4'd9; dx[1] = 4'd15; dy[1] = 4'd0;  end
    endcase
    for (int i = 0; i < 2 + nrand; i++) begin
      x = (i < 2) ? dx[i] : 4'($urandom);
      y = (i < 2) ? dy[i] : 4'($urandom);
      exp_res = 8'(model(4, int'(m), int'(x), int'(y)));
      exp_lat = latency(4, int'(m));
      do_op4(m, x, y, scramble, lat, res, err_at_done, hs_ok, stable, done_after);
      checks++; if (res !== exp_res) begin
        errors++; $display("FAIL result m=%0d a=%0d b=%0d got=%h want=%h", m, x, y, res, exp_res);
      end
      checks++; if (lat !== exp_lat) begin
        errors++; $display("FAIL latency m=%0d a=%0d b=%0d got=%0d want=%0d", m, x, y, lat, exp_lat);
      end
      checks++; if (err_at_done !== (m == 2'd3)) begin
        errors++; $display("FAIL err m=%0d got=%b want=%b", m, err_at_done, (m == 2'd3));
      end
      checks++; if (!hs_ok) begin
        errors++; $display("FAIL busy_handshake m=%0d got=0 want=1", m);
      end
      checks++; if (!stable) begin
        errors++; $display("FAIL busy_or_result_stable m=%0d got=0 want=1", m);
      end
      checks++; if (done_after !== 1'b0) begin
        errors++; $display("FAIL done_one_cycle m=%0d got=%b want=0", m, done_after);
      end
    end
  endtask

  task automatic test_mul8;
    logic [7:0] x, y;
    int lat;
    for (int i = 0; i < 4; i++) begin
      x = (i == 0) ? 8'd255 : 8'($urandom);
      y = (i == 0) ? 8'd255 : 8'($urandom);
      start8 = 1'b1; mode8 = 2'd2; a8 = x; b8 = y;
      tick;
      start8 = 1'b0;
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
        tick;
        if (done8 === 1'b1) begin lat = k; break; end
      end
      checks++; if (lat !== 72) begin
        errors++; $display("FAIL mul8_latency a=%0d b=%0d got=%0d want=72", x, y, lat);
      end
      checks++; if (result8 !== 16'(model(8, 2, int'(x), int'(y)))) begin
        errors++; $display("FAIL mul8_result a=%0d b=%0d got=%h want=%h", x, y, result8,
                           16'(model(8, 2, int'(x), int'(y))));
      end
      tick;
    end
  endtask

  task automatic test_abort;
    int lat;
    logic [7:0] res;
    logic err_at_done, done_after;
    bit hs_ok, stable, saw_done;
    do_op4(2'd2, 4'd15, 4'd15, 1'b0, lat, res, err_at_done, hs_ok, stable, done_after);
    checks++; if (res !== 8'hE1) begin
      errors++; $display("FAIL abort_setup got=%h want=e1", res);
    end
    start4 = 1'b1; mode4 = 2'd2; a4 = 4'd7; b4 = 4'd7;
    tick;
    start4 = 1'b0;
    repeat (9) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0 || result4 !== 8'h00) begin
      errors++; $display("FAIL abort_state got busy=%b done=%b result=%h want 0 0 00", busy4, done4, result4);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (done4 !== 1'b0 || busy4 !== 1'b0) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin
      errors++; $display("FAIL abort_no_done got=1 want=0");
    end
  endtask

  task automatic test_back_to_back;
    int times[$];
    bit res_ok;
    res_ok = 1'b1;
    start4 = 1'b1; mode4 = 2'd0; a4 = 4'd9; b4 = 4'd8;
    tick;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (done4 === 1'b1) begin
        times.push_back(k);
        if (result4 !== 8'h11) res_ok = 1'b0;
      end
    end
    start4 = 1'b0;
    tick; tick;
    checks++; if (times.size() !== 7) begin
      errors++; $display("FAIL b2b_count got=%0d want=7", times.size());
    end
    checks++; if (times.size() == 0 || times[0] !== 4) begin
      errors++; $display("FAIL b2b_first got=%0d want=4", (times.size() == 0) ? -1 : times[0]);
    end
    for (int i = 1; i < times.size(); i++) begin
      checks++; if (times[i] - times[i-1] !== 6) begin
        errors++; $display("FAIL b2b_gap idx=%0d got=%0d want=6", i, times[i] - times[i-1]);
      end
    end
    checks++; if (!res_ok) begin
      errors++; $display("FAIL b2b_result got=0 want=1");
    end
  endtask

  initial begin
    reset = 1'b1; start4 = 1'b0; start8 = 1'b0;
    mode4 = '0; mode8 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    test_reset;
    test_arith(2'd0, 8, 1'b0);
    test_arith(2'd1, 8, 1'b0);
    test_arith(2'd2, 6, 1'b0);
    test_mul8;
    test_arith(2'd3, 1, 1'b0);
    for (int m = 0; m < 3; m++) test_arith(2'(m), 4, 1'b1);
    test_abort;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
